// File: rtl/dp_arbiter_if.sv
// ============================================================================
// Module  : dp_arbiter_if
// Purpose : Requester and BCU data-pointer signals shared by dp_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface dp_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   req_addr;
    logic [16*NREQ-1:0]   req_dout;
    logic [2*NREQ-1:0]    req_sreg;
    logic [NREQ-1:0]      req_write;
    logic [NREQ-1:0]      req_wide;
    logic [NREQ-1:0]      req_io;
    logic [NREQ-1:0]      req_zero_seg;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ-1:0]      done;
    logic [15:0]          res_din;
    logic [15:0]          dp_addr;
    logic [15:0]          dp_dout;
    logic [1:0]           dp_sreg;
    logic                 dp_write;
    logic                 dp_wide;
    logic                 dp_io;
    logic                 dp_zero_seg;
    logic                 dp_req;
    logic [15:0]          dp_din;
    logic                 dp_ready;
    logic                 buslock_prefix;

    // Arbiter side
    modport slave (
        input  req, req_addr, req_dout, req_sreg, req_write, req_wide, req_io,
               req_zero_seg, req_lock, dp_din, dp_ready,
        output done, res_din, dp_addr, dp_dout, dp_sreg, dp_write, dp_wide, dp_io,
               dp_zero_seg, dp_req, buslock_prefix
    );

    // Requesters plus BCU side
    modport master (
        output req, req_addr, req_dout, req_sreg, req_write, req_wide, req_io,
               req_zero_seg, req_lock, dp_din, dp_ready,
        input  done, res_din, dp_addr, dp_dout, dp_sreg, dp_write, dp_wide, dp_io,
               dp_zero_seg, dp_req, buslock_prefix
    );
endinterface

`default_nettype wire

// File: rtl/dp_arbiter.sv
// ============================================================================
// Module  : dp_arbiter
// Purpose : Round-robin sharing of the BCU data-pointer port among NREQ
//           requesters. Optional bus-lock support under `DP_ARB_LOCK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dp_arbiter #(
    parameter int NREQ = 2
) (
    input  wire logic    clk,
    input  wire logic    n_reset,
    input  wire logic    ce_1,
    input  wire logic    ce_2,
    dp_arbiter_if.slave  bus
);
    localparam int         C_PTR_W = (NREQ > 2) ? 2 : 1;
    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_ISSUE = 2'd1;
    localparam logic [1:0] C_WAIT  = 2'd2;
    localparam logic [1:0] C_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_en;
    logic [NREQ-1:0]    w_elig;
    logic               w_any;
    logic [C_PTR_W-1:0] w_sel;
    logic [C_PTR_W-1:0] r_rr_ptr;
    logic [C_PTR_W-1:0] r_gnt;
    logic               w_regrant;

    logic [15:0]        w_sel_addr;
    logic [15:0]        w_sel_dout;
    logic [1:0]         w_sel_sreg;
    logic [3:0]         w_sel_flags;
    logic               w_sel_lock;

    logic [15:0]        r_dp_addr;
    logic [15:0]        r_dp_dout;
    logic [1:0]         r_dp_sreg;
    logic [3:0]         r_dp_flags;
    logic [15:0]        r_res_din;

    assign w_en = ce_1 | ce_2;

`ifdef DP_ARB_LOCK_EN
    logic               r_lock_vld;
    logic [C_PTR_W-1:0] r_lock_owner;
    logic               r_lock_cur;
    logic [2:0]         r_idle_cnt;

    assign w_elig    = r_lock_vld ? (bus.req & (NREQ'(1) << r_lock_owner)) : bus.req;
    assign w_regrant = r_lock_vld;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_lock_vld   <= 1'b0;
            r_lock_owner <= '0;
            r_lock_cur   <= 1'b0;
            r_idle_cnt   <= '0;
        end else if (w_en) begin
            case (r_state)
                C_IDLE: begin
                    if (w_any) begin
                        r_lock_cur <= w_sel_lock;
                        r_idle_cnt <= '0;
                        if (w_sel_lock) begin
                            r_lock_vld   <= 1'b1;
                            r_lock_owner <= w_sel;
                        end
                    end else if (r_lock_vld) begin
                        // Owner silent for 8 enabled IDLE cycles: release the bus
                        if (r_idle_cnt == 3'd7) begin
                            r_lock_vld <= 1'b0;
                            r_idle_cnt <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 3'd1;
                        end
                    end
                end
                C_DONE: begin
                    if (!r_lock_cur) r_lock_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.buslock_prefix = r_lock_vld;
`else
    logic w_unused_lock;

    assign w_elig             = bus.req;
    assign w_regrant          = 1'b0;
    assign w_unused_lock      = ^{bus.req_lock, w_sel_lock};
    assign bus.buslock_prefix = 1'b0;
`endif

    // Round-robin search: indices above rr_ptr first, then wrap to 0..rr_ptr
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any && (i > int'(r_rr_ptr)) && w_elig[i]) begin
                w_any = 1'b1;
                w_sel = C_PTR_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any && (i <= int'(r_rr_ptr)) && w_elig[i]) begin
                w_any = 1'b1;
                w_sel = C_PTR_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_dout  = '0;
        w_sel_sreg  = '0;
        w_sel_flags = '0;
        w_sel_lock  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == C_PTR_W'(i)) begin
                w_sel_addr  = bus.req_addr[16*i +: 16];
                w_sel_dout  = bus.req_dout[16*i +: 16];
                w_sel_sreg  = bus.req_sreg[2*i +: 2];
                w_sel_flags = {bus.req_write[i], bus.req_wide[i],
                               bus.req_io[i], bus.req_zero_seg[i]};
                w_sel_lock  = bus.req_lock[i];
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r_state <= C_IDLE;
        else if (w_en) r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE:  if (w_any) w_state_nxt = C_ISSUE;
            C_ISSUE: w_state_nxt = C_WAIT;
            C_WAIT:  if (bus.dp_ready) w_state_nxt = C_DONE;
            default: w_state_nxt = C_IDLE;
        endcase
    end

    always_comb begin
        bus.dp_req = (r_state == C_ISSUE);
        bus.done   = (r_state == C_DONE) ? (NREQ'(1) << r_gnt) : '0;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_rr_ptr   <= C_PTR_W'(NREQ - 1);
            r_gnt      <= '0;
            r_dp_addr  <= '0;
            r_dp_dout  <= '0;
            r_dp_sreg  <= '0;
            r_dp_flags <= '0;
            r_res_din  <= '0;
        end else if (w_en) begin
            if ((r_state == C_IDLE) && w_any) begin
                r_gnt      <= w_sel;
                r_dp_addr  <= w_sel_addr;
                r_dp_dout  <= w_sel_dout;
                r_dp_sreg  <= w_sel_sreg;
                r_dp_flags <= w_sel_flags;
                if (!w_regrant) r_rr_ptr <= w_sel;
            end
            if ((r_state == C_WAIT) && bus.dp_ready) r_res_din <= bus.dp_din;
        end
    end

    assign bus.dp_addr     = r_dp_addr;
    assign bus.dp_dout     = r_dp_dout;
    assign bus.dp_sreg     = r_dp_sreg;
    assign bus.dp_write    = r_dp_flags[3];
    assign bus.dp_wide     = r_dp_flags[2];
    assign bus.dp_io       = r_dp_flags[1];
    assign bus.dp_zero_seg = r_dp_flags[0];
    assign bus.res_din     = r_res_din;

endmodule

`default_nettype wire

// File: tb/tb_dp_arbiter.sv
// ============================================================================
// Module  : tb_dp_arbiter
// Purpose : Scoreboard bench for dp_arbiter with a BCU responder model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dp_arbiter;
    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic ce_1 = 1'b1;
    logic ce_2 = 1'b0;

    always #5 clk = ~clk;

    dp_arbiter_if #(.NREQ(NREQ)) bus();

    dp_arbiter #(.NREQ(NREQ)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .ce_1    (ce_1),
        .ce_2    (ce_2),
        .bus     (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  done;
        logic [15:0] data;
    } sb_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] dout;
        logic [1:0]  sreg;
        logic [3:0]  flags;
        logic [15:0] data;
        int          lat;
        bit          abort;
    } bfm_t;

    sb_t  sb_q[$];
    bfm_t bfm_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected completion order, fed to both the BCU model and the scoreboard
    task automatic expect_txn(input int i, input logic [15:0] addr, input logic [15:0] dout,
                              input logic [1:0] sreg, input logic [3:0] fl,
                              input logic [15:0] data, input int lat, input bit abort);
        bfm_t b;
        sb_t  s;
        b.addr = addr; b.dout = dout; b.sreg = sreg; b.flags = fl;
        b.data = data; b.lat = lat; b.abort = abort;
        bfm_q.push_back(b);
        if (!abort) begin
            s.done = 2'(1 << i);
            s.data = data;
            sb_q.push_back(s);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] addr, input logic [15:0] dout,
                           input logic [1:0] sreg, input logic [3:0] fl, input logic lk);
        bus.req_addr[16*i +: 16] = addr;
        bus.req_dout[16*i +: 16] = dout;
        bus.req_sreg[2*i +: 2]   = sreg;
        bus.req_write[i]         = fl[3];
        bus.req_wide[i]          = fl[2];
        bus.req_io[i]            = fl[1];
        bus.req_zero_seg[i]      = fl[0];
        bus.req_lock[i]          = lk;
        bus.req[i]               = 1'b1;
    endtask

    task automatic wait_done(input int i);
        bit seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (bus.done[i]) seen = 1'b1;
        end
        chk("done_wait", 32'(seen), 32'd1);
    endtask

    task automatic wait_req();
        bit seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (bus.dp_req) seen = 1'b1;
        end
        chk("dp_req_wait", 32'(seen), 32'd1);
    endtask

    // Scoreboard monitor
    sb_t m_e;
    always @(negedge clk) begin
        if (n_reset && bus.done != '0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                m_e = sb_q.pop_front();
                chk("done", 32'(bus.done), 32'(m_e.done));
                chk("res_din", 32'(bus.res_din), 32'(m_e.data));
            end
        end
    end

    // BCU responder model
    bfm_t f_b;
    initial begin
        bus.dp_ready = 1'b0;
        bus.dp_din   = '0;
        forever begin
            @(negedge clk);
            if (n_reset && bus.dp_req) begin
                if (bfm_q.size() == 0) begin
                    chk("unexpected_dp_req", 32'(bus.dp_req), 32'd0);
                end else begin
                    f_b = bfm_q.pop_front();
                    chk("dp_addr", 32'(bus.dp_addr), 32'(f_b.addr));
                    chk("dp_dout", 32'(bus.dp_dout), 32'(f_b.dout));
                    chk("dp_sreg", 32'(bus.dp_sreg), 32'(f_b.sreg));
                    chk("dp_flags", 32'({bus.dp_write, bus.dp_wide, bus.dp_io, bus.dp_zero_seg}),
                        32'(f_b.flags));
                    @(negedge clk);
                    chk("dp_req_pulse", 32'(bus.dp_req), 32'd0);
                    if (!f_b.abort) begin
                        repeat (f_b.lat - 1) @(negedge clk);
                        bus.dp_din   = f_b.data;
                        bus.dp_ready = 1'b1;
                        @(negedge clk);
                        bus.dp_ready = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req = '0; bus.req_addr = '0; bus.req_dout = '0; bus.req_sreg = '0;
        bus.req_write = '0; bus.req_wide = '0; bus.req_io = '0;
        bus.req_zero_seg = '0; bus.req_lock = '0;

        repeat (3) @(negedge clk);
        chk("rst_dp_req", 32'(bus.dp_req), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_res_din", 32'(bus.res_din), 32'd0);
        chk("rst_dp_addr", 32'(bus.dp_addr), 32'd0);
        chk("rst_dp_flags", 32'({bus.dp_sreg, bus.dp_write, bus.dp_wide, bus.dp_io,
                                 bus.dp_zero_seg}), 32'd0);
        chk("rst_buslock", 32'(bus.buslock_prefix), 32'd0);
        n_reset = 1'b1;

        // Contention: both held, grants alternate starting at 0
        expect_txn(0, 16'hA000, 16'h0000, 2'd0, 4'b0000, 16'h1001, 1, 1'b0);
        expect_txn(1, 16'hB111, 16'h5555, 2'd2, 4'b1100, 16'h1002, 2, 1'b0);
        expect_txn(0, 16'hA000, 16'h0000, 2'd0, 4'b0000, 16'h1003, 1, 1'b0);
        expect_txn(1, 16'hB111, 16'h5555, 2'd2, 4'b1100, 16'h1004, 2, 1'b0);
        set_req(0, 16'hA000, 16'h0000, 2'd0, 4'b0000, 1'b0);
        set_req(1, 16'hB111, 16'h5555, 2'd2, 4'b1100, 1'b0);
        wait_done(0);
        wait_done(1);
        wait_done(0);
        wait_done(1);
        bus.req = '0;

        // Single wide read
        expect_txn(0, 16'h1234, 16'h0000, 2'd3, 4'b0100, 16'hBEEF, 3, 1'b0);
        set_req(0, 16'h1234, 16'h0000, 2'd3, 4'b0100, 1'b0);
        wait_done(0);
        bus.req[0] = 1'b0;

        // Request dropped while waiting still completes exactly once
        expect_txn(1, 16'h2222, 16'hABCD, 2'd1, 4'b1000, 16'h7777, 4, 1'b0);
        set_req(1, 16'h2222, 16'hABCD, 2'd1, 4'b1000, 1'b0);
        wait_req();
        @(negedge clk);
        bus.req[1] = 1'b0;
        wait_done(1);
        repeat (6) @(negedge clk);

        // Phase enables low: nothing moves
        ce_1 = 1'b0;
        expect_txn(0, 16'h3333, 16'h0000, 2'd0, 4'b0010, 16'h6666, 2, 1'b0);
        set_req(0, 16'h3333, 16'h0000, 2'd0, 4'b0010, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("gated_dp_req", 32'(bus.dp_req), 32'd0);
            chk("gated_done", 32'(bus.done), 32'd0);
        end
        ce_2 = 1'b1;
        wait_done(0);
        bus.req[0] = 1'b0;
        ce_1 = 1'b1;
        ce_2 = 1'b0;

        // Reset while waiting for the BCU
        expect_txn(0, 16'h4444, 16'h0000, 2'd0, 4'b0000, 16'h0000, 1, 1'b1);
        set_req(0, 16'h4444, 16'h0000, 2'd0, 4'b0000, 1'b0);
        wait_req();
        @(negedge clk);
        @(negedge clk);
        #2 n_reset = 1'b0;
        #1;
        chk("arst_dp_req", 32'(bus.dp_req), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_dp_addr", 32'(bus.dp_addr), 32'd0);
        chk("arst_res_din", 32'(bus.res_din), 32'd0);
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        expect_txn(1, 16'h5151, 16'h0000, 2'd2, 4'b0001, 16'h9999, 2, 1'b0);
        set_req(1, 16'h5151, 16'h0000, 2'd2, 4'b0001, 1'b0);
        wait_done(1);
        bus.req[1] = 1'b0;
        repeat (3) @(negedge clk);

`ifdef DP_ARB_LOCK_EN
        // Locked pair for requester 1, then requester 0
        expect_txn(0, 16'h0A0A, 16'h0000, 2'd0, 4'b0000, 16'hC001, 1, 1'b0);
        expect_txn(1, 16'h0B0B, 16'h0000, 2'd1, 4'b0000, 16'hC002, 1, 1'b0);
        expect_txn(1, 16'h0B0B, 16'h0000, 2'd1, 4'b0000, 16'hC003, 1, 1'b0);
        expect_txn(0, 16'h0A0A, 16'h0000, 2'd0, 4'b0000, 16'hC004, 1, 1'b0);
        set_req(0, 16'h0A0A, 16'h0000, 2'd0, 4'b0000, 1'b0);
        set_req(1, 16'h0B0B, 16'h0000, 2'd1, 4'b0000, 1'b1);
        wait_done(0);
        wait_done(1);
        chk("lock_first", 32'(bus.buslock_prefix), 32'd1);
        bus.req_lock[1] = 1'b0;
        wait_done(1);
        chk("lock_second", 32'(bus.buslock_prefix), 32'd1);
        wait_done(0);
        chk("lock_released", 32'(bus.buslock_prefix), 32'd0);
        bus.req = '0;
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("bfm_empty", 32'(bfm_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
